// File: rtl/dma_ctrl.sv
// dma_ctrl: bus-master DMA between the RS232 RX FIFO / transmitter and the data RAM.
// Latency: a grant is sampled in REQ; the first bus cycle follows on the next clock. All outputs are registered.
// Backpressure: waits in REQ for DMA_ACK, and holds the bus in TX_SEND until TX_RDY.
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   RCVD_Data, RX_Empty, Data_Read   show-ahead RX FIFO head byte, empty flag, pop strobe
//   TX_Data, Valid_D, TX_RDY         byte, strobe and ready towards the transmitter
//   Send_comm         CPU pulse asking for the transmit buffer to be sent
//   DMA_RQ, DMA_ACK, READY           bus request/grant with the CPU, idle indication
//   Address, DataOut, DataIn, Cs, Wen, Oen   RAM bus (outputs are 0 when no cycle is issued)
module dma_ctrl #(
  parameter logic [7:0]  RX_BASE   = 8'h00,
  parameter int unsigned RX_LEN    = 3,
  parameter logic [7:0]  FLAG_ADDR = 8'h03,
  parameter logic [7:0]  FLAG_VAL  = 8'hFF,
  parameter logic [7:0]  TX_BASE   = 8'h04,
  parameter int unsigned TX_LEN    = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] RCVD_Data,
  input  logic       RX_Empty,
  output logic       Data_Read,
  input  logic       TX_RDY,
  output logic [7:0] TX_Data,
  output logic       Valid_D,
  input  logic       Send_comm,
  output logic       DMA_RQ,
  input  logic       DMA_ACK,
  output logic       READY,
  output logic [7:0] Address,
  output logic [7:0] DataOut,
  input  logic [7:0] DataIn,
  output logic       Cs,
  output logic       Wen,
  output logic       Oen
);

  localparam logic [7:0] RX_LAST = 8'(RX_LEN - 1);
  localparam logic [7:0] TX_LAST = 8'(TX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RX_WR,
    S_RX_FLAG,
    S_TX_RD,
    S_TX_CAP,
    S_TX_SEND,
    S_REL
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rx_ptr_q, rx_ptr_d;
  logic [7:0] tx_idx_q, tx_idx_d;
  logic       tx_pend_q, tx_pend_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       vld_q, vld_d;
  logic       data_read_q, data_read_d;
  logic       dma_rq_q, dma_rq_d;
  logic       ready_q, ready_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       cs_q, cs_d;
  logic       wen_q, wen_d;
  logic       oen_q, oen_d;

  // Outputs are decoded from the next state so that every strobe is a flop
  // and is valid for exactly the cycle the FSM spends in the issuing state.
  always_comb begin
    state_d     = state_q;
    rx_ptr_d    = rx_ptr_q;
    tx_idx_d    = tx_idx_q;
    tx_pend_d   = tx_pend_q | Send_comm;
    tx_byte_d   = tx_byte_q;
    tx_data_d   = tx_data_q;
    vld_d       = 1'b0;
    data_read_d = 1'b0;
    cs_d        = 1'b0;
    wen_d       = 1'b0;
    oen_d       = 1'b0;
    addr_d      = 8'h00;
    dout_d      = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (tx_pend_q || Send_comm || !RX_Empty) state_d = S_REQ;
      end
      S_REQ: begin
        if (DMA_ACK) begin
          // A Send_comm pulse landing on the grant cycle is honoured directly,
          // so transmit still wins over a waiting RX byte.
          if (tx_pend_q || Send_comm) begin
            state_d   = S_TX_RD;
            tx_pend_d = 1'b0;
            tx_idx_d  = 8'h00;
            cs_d      = 1'b1;
            oen_d     = 1'b1;
            addr_d    = TX_BASE;
          end else if (!RX_Empty) begin
            state_d     = S_RX_WR;
            cs_d        = 1'b1;
            wen_d       = 1'b1;
            data_read_d = 1'b1;
            addr_d      = RX_BASE + rx_ptr_q;
            dout_d      = RCVD_Data;
          end else begin
            state_d = S_REL;
          end
        end
      end
      S_RX_WR: begin
        if (rx_ptr_q == RX_LAST) begin
          rx_ptr_d = 8'h00;
          state_d  = S_RX_FLAG;
          cs_d     = 1'b1;
          wen_d    = 1'b1;
          addr_d   = FLAG_ADDR;
          dout_d   = FLAG_VAL;
        end else begin
          rx_ptr_d = rx_ptr_q + 8'd1;
          state_d  = S_REL;
        end
      end
      S_RX_FLAG: state_d = S_REL;
      S_TX_RD:   state_d = S_TX_CAP;
      S_TX_CAP: begin
        // RAM read data is valid in the cycle after Cs/Oen.
        tx_byte_d = DataIn;
        state_d   = S_TX_SEND;
      end
      S_TX_SEND: begin
        if (TX_RDY) begin
          vld_d     = 1'b1;
          tx_data_d = tx_byte_q;
          if (tx_idx_q == TX_LAST) begin
            state_d = S_REL;
          end else begin
            tx_idx_d = tx_idx_q + 8'd1;
            state_d  = S_TX_RD;
            cs_d     = 1'b1;
            oen_d    = 1'b1;
            addr_d   = TX_BASE + tx_idx_d;
          end
        end
      end
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    dma_rq_d = (state_d != S_IDLE) && (state_d != S_REL);
    ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      rx_ptr_q    <= 8'h00;
      tx_idx_q    <= 8'h00;
      tx_pend_q   <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_data_q   <= 8'h00;
      vld_q       <= 1'b0;
      data_read_q <= 1'b0;
      dma_rq_q    <= 1'b0;
      ready_q     <= 1'b1;
      addr_q      <= 8'h00;
      dout_q      <= 8'h00;
      cs_q        <= 1'b0;
      wen_q       <= 1'b0;
      oen_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ptr_q    <= rx_ptr_d;
      tx_idx_q    <= tx_idx_d;
      tx_pend_q   <= tx_pend_d;
      tx_byte_q   <= tx_byte_d;
      tx_data_q   <= tx_data_d;
      vld_q       <= vld_d;
      data_read_q <= data_read_d;
      dma_rq_q    <= dma_rq_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      cs_q        <= cs_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
    end
  end

  assign Data_Read = data_read_q;
  assign TX_Data   = tx_data_q;
  assign Valid_D   = vld_q;
  assign DMA_RQ    = dma_rq_q;
  assign READY     = ready_q;
  assign Address   = addr_q;
  assign DataOut   = dout_q;
  assign Cs        = cs_q;
  assign Wen       = wen_q;
  assign Oen       = oen_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: bench for dma_ctrl with RAM, RX FIFO, CPU arbiter and transmitter models.
// Latency: models update on the falling edge; DUT outputs are sampled there too.
// Backpressure: grant latency and TX_RDY are set per test.
module tb_dma_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] RCVD_Data;
  logic       RX_Empty;
  logic       Data_Read;
  logic       TX_RDY;
  logic [7:0] TX_Data;
  logic       Valid_D;
  logic       Send_comm;
  logic       DMA_RQ;
  logic       DMA_ACK;
  logic       READY;
  logic [7:0] Address;
  logic [7:0] DataOut;
  logic [7:0] DataIn;
  logic       Cs;
  logic       Wen;
  logic       Oen;

  always #5 Clk = ~Clk;

  dma_ctrl dut (
    .Clk(Clk), .Rst(Rst), .RCVD_Data(RCVD_Data), .RX_Empty(RX_Empty),
    .Data_Read(Data_Read), .TX_RDY(TX_RDY), .TX_Data(TX_Data), .Valid_D(Valid_D),
    .Send_comm(Send_comm), .DMA_RQ(DMA_RQ), .DMA_ACK(DMA_ACK), .READY(READY),
    .Address(Address), .DataOut(DataOut), .DataIn(DataIn), .Cs(Cs), .Wen(Wen), .Oen(Oen)
  );

  int checks = 0;
  int errors = 0;

  // Environment state
  logic [7:0]  mem [256];
  logic [7:0]  fifo [$];
  logic [15:0] wq [$];     // expected RAM writes {addr, data}
  logic [7:0]  txq [$];    // expected transmitted bytes
  logic [7:0]  raq [$];    // expected RAM read addresses
  int ack_lat = 1;
  int rq_cnt = 0;
  int rd_age = 2;
  bit prev_rq = 1'b0;
  bit ack_rise_pend = 1'b0;
  bit order_chk = 1'b0;
  int pops, rq_falls, wait_cyc, reads, valids;

  typedef struct {
    logic [7:0] rx_byte;
    int         lat;
    logic [7:0] exp_addr;
    bit         exp_flag;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  task automatic clr_counts();
    pops = 0; rq_falls = 0; wait_cyc = 0; reads = 0; valids = 0;
  endtask

  task automatic upd_rx();
    RX_Empty  = (fifo.size() == 0);
    RCVD_Data = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  task automatic push_rx(input logic [7:0] b);
    fifo.push_back(b);
    upd_rx();
  endtask

  // One clock: sample the DUT at the falling edge, run the models, check events.
  task automatic cyc();
    logic [15:0] e;
    bit new_ack;
    @(negedge Clk);
    if (Cs !== 1'b1)
      chk("bus_idle_zero", {16'h0, Address, DataOut} | {30'h0, Wen, Oen}, 32'h0);
    else
      chk("cs_with_grant", DMA_ACK, 1);
    if (ack_rise_pend) begin
      chk("cycle_after_grant_cs", Cs, 1);
      ack_rise_pend = 1'b0;
    end
    if (DMA_RQ === 1'b1 && DMA_ACK === 1'b0) begin
      wait_cyc++;
      chk("wait_no_cs_pop", {Cs, Data_Read}, 0);
    end
    if (Cs === 1'b1 && Wen === 1'b1) begin
      if (order_chk) chk("tx_before_rx", txq.size(), 0);
      if (wq.size() == 0) fail_evt("spurious_write", {Address, DataOut});
      else begin
        e = wq.pop_front();
        chk("wr_addr", Address, e[15:8]);
        chk("wr_data", DataOut, e[7:0]);
      end
      mem[Address] = DataOut;
    end
    if (Cs === 1'b1 && Oen === 1'b1) begin
      reads++;
      if (raq.size() == 0) fail_evt("spurious_read", Address);
      else chk("rd_addr", Address, raq.pop_front());
      DataIn = mem[Address];
      rd_age = 0;
    end else begin
      if (rd_age < 2) rd_age++;
      if (rd_age >= 2) DataIn = 8'hEE;
    end
    if (Data_Read === 1'b1) begin
      pops++;
      chk("pop_with_write", Cs & Wen, 1);
      if (fifo.size() == 0) fail_evt("pop_empty", 0);
      else void'(fifo.pop_front());
    end
    if (Valid_D === 1'b1) begin
      valids++;
      if (txq.size() == 0) fail_evt("spurious_valid", TX_Data);
      else chk("tx_data", TX_Data, txq.pop_front());
    end
    if (prev_rq && DMA_RQ !== 1'b1) rq_falls++;
    prev_rq = (DMA_RQ === 1'b1);
    // CPU arbiter: grant after ack_lat cycles of request, drop with the request.
    if (DMA_RQ === 1'b1) begin
      rq_cnt++;
      new_ack = (rq_cnt >= ack_lat);
    end else begin
      rq_cnt  = 0;
      new_ack = 1'b0;
    end
    if (new_ack && DMA_ACK !== 1'b1) ack_rise_pend = 1'b1;
    DMA_ACK = new_ack;
    upd_rx();
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < max) begin
      cyc();
      n++;
      done = (READY === 1'b1) && fifo.size() == 0 && wq.size() == 0 &&
             txq.size() == 0 && raq.size() == 0;
    end
    if (!done) fail_evt("timeout_idle", n);
    repeat (3) cyc();
  endtask

  task automatic send_pulse();
    Send_comm = 1'b1;
    cyc();
    Send_comm = 1'b0;
  endtask

  initial begin
    bit hit;
    vecs[0] = '{8'hA1, 1,  8'h00, 1'b0};
    vecs[1] = '{8'hB2, 1,  8'h01, 1'b0};
    vecs[2] = '{8'hC3, 1,  8'h02, 1'b1};
    vecs[3] = '{8'h11, 1,  8'h00, 1'b0};
    vecs[4] = '{8'h22, 20, 8'h01, 1'b0};
    vecs[5] = '{8'h33, 2,  8'h02, 1'b1};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Rst = 1'b1; TX_RDY = 1'b1; Send_comm = 1'b0; DMA_ACK = 1'b0; DataIn = 8'h00;
    upd_rx();
    clr_counts();

    // Reset state
    cyc(); cyc();
    chk("rst_ready", READY, 1);
    chk("rst_dma_rq", DMA_RQ, 0);
    chk("rst_data_read", Data_Read, 0);
    chk("rst_valid_d", Valid_D, 0);
    chk("rst_tx_data", TX_Data, 0);
    chk("rst_cs_wen_oen", {Cs, Wen, Oen}, 0);
    chk("rst_address", Address, 0);
    chk("rst_dataout", DataOut, 0);
    Rst = 1'b0;

    // Partial frame, then reset during the second byte's write cycle
    push_rx(8'h98); wq.push_back({8'h00, 8'h98});
    wait_done(100);
    push_rx(8'h99); wq.push_back({8'h01, 8'h99});
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      cyc();
      hit = (Cs === 1'b1 && Wen === 1'b1);
    end
    if (!hit) fail_evt("timeout_mid_write", 0);
    Rst = 1'b1;
    cyc();
    chk("midrst_strobes", {Cs, Wen, Oen, Data_Read, Valid_D}, 0);
    chk("midrst_ready", READY, 1);
    chk("midrst_dma_rq", DMA_RQ, 0);
    Rst = 1'b0;
    cyc(); cyc();
    chk("midrst_no_write", {Cs, Data_Read}, 0);

    // Table: two full frames after the aborted one, varying grant latency
    for (int i = 0; i < 6; i++) begin
      clr_counts();
      ack_lat = vecs[i].lat;
      push_rx(vecs[i].rx_byte);
      wq.push_back({vecs[i].exp_addr, vecs[i].rx_byte});
      if (vecs[i].exp_flag) wq.push_back({8'h03, 8'hFF});
      wait_done(200);
      chk($sformatf("v%0d_pops", i), pops, 1);
      chk($sformatf("v%0d_rq_drop", i), rq_falls, 1);
      chk($sformatf("v%0d_grant_wait", i), wait_cyc, vecs[i].lat);
      chk($sformatf("v%0d_ram", i), mem[vecs[i].exp_addr], vecs[i].rx_byte);
    end
    chk("frame_flag", mem[3], 8'hFF);

    // TX: two bytes, bus held across both
    ack_lat = 1;
    mem[4] = 8'h55; mem[5] = 8'h3C;
    clr_counts();
    txq.push_back(8'h55); txq.push_back(8'h3C);
    raq.push_back(8'h04); raq.push_back(8'h05);
    send_pulse();
    wait_done(200);
    chk("tx_valids", valids, 2);
    chk("tx_reads", reads, 2);
    chk("tx_single_release", rq_falls, 1);
    chk("tx_released", {DMA_RQ, READY}, 2'b01);
    chk("tx_data_hold", TX_Data, 8'h3C);

    // TX back-pressure
    clr_counts();
    TX_RDY = 1'b0;
    txq.push_back(8'h55); txq.push_back(8'h3C);
    raq.push_back(8'h04); raq.push_back(8'h05);
    send_pulse();
    for (int i = 0; i < 50 && reads == 0; i++) cyc();
    if (reads == 0) fail_evt("timeout_tx_read", 0);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("bp_no_valid", Valid_D, 0);
      chk("bp_rq_held", DMA_RQ, 1);
    end
    TX_RDY = 1'b1;
    wait_done(200);
    chk("bp_valids", valids, 2);

    // Send_comm together with a waiting RX byte: TX first, then the byte
    clr_counts();
    order_chk = 1'b1;
    txq.push_back(8'h55); txq.push_back(8'h3C);
    raq.push_back(8'h04); raq.push_back(8'h05);
    wq.push_back({8'h00, 8'h7E});
    push_rx(8'h7E);
    send_pulse();
    wait_done(300);
    order_chk = 1'b0;
    chk("simul_ram", mem[0], 8'h7E);
    chk("simul_pops", pops, 1);
    // rx_ptr must now be 1: the next byte lands at 0x01 with no flag
    push_rx(8'h5A); wq.push_back({8'h01, 8'h5A});
    wait_done(200);
    chk("simul_next_ptr", mem[1], 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
